// File: rtl/pc_update_unit.sv
// Program-counter stage: holds PC and EPC, qualifies PC writes with ALU flags and
// runs the multi-cycle exception sequence that fetches the handler from the vector table.
module pc_update_unit #(
  parameter logic [31:0] RESET_PC   = 32'd0,
  parameter logic [31:0] VEC_BASE   = 32'd253,
  parameter logic [31:0] EPC_OFFSET = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic        exc_req,
  input  logic [1:0]  exc_code,
  input  logic [7:0]  mem_byte,
  output logic [31:0] pc_out,
  output logic [31:0] epc_out,
  output logic [31:0] vec_addr,
  output logic        vec_rd,
  output logic        exc_busy
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StSave = 3'd1;
  localparam logic [2:0] StRead = 3'd2;
  localparam logic [2:0] StWait = 3'd3;
  localparam logic [2:0] StLoad = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] vec_addr_q, vec_addr_d;
  logic        vec_rd_q, vec_rd_d;
  logic [1:0]  code_q, code_d;
  logic [7:0]  byte_q, byte_d;
  logic        cond_true;

  always_comb begin
    cond_true = 1'b0;
    case (branch_op)
      2'd0:    cond_true = alu_zero;
      2'd1:    cond_true = !alu_zero;
      2'd2:    cond_true = alu_zero | !alu_gt;
      default: cond_true = alu_gt;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    epc_d      = epc_q;
    vec_addr_d = vec_addr_q;
    vec_rd_d   = vec_rd_q;
    code_d     = code_q;
    byte_d     = byte_q;
    case (state_q)
      StIdle: begin
        // An exception request wins over any simultaneous PC write.
        if (exc_req) begin
          state_d = StSave;
          code_d  = (exc_code == 2'd3) ? 2'd0 : exc_code;
        end else if (pc_write) begin
          pc_d = pc_in;
        end else if (pc_write_cond && cond_true) begin
          pc_d = pc_in;
        end
      end
      StSave: begin
        epc_d      = pc_q - EPC_OFFSET;
        vec_addr_d = VEC_BASE + {30'd0, code_q};
        vec_rd_d   = 1'b1;
        state_d    = StRead;
      end
      StRead: begin
        vec_rd_d = 1'b0;
        state_d  = StWait;
      end
      StWait: begin
        byte_d  = mem_byte;
        state_d = StLoad;
      end
      StLoad: begin
        pc_d       = {24'd0, byte_q};
        vec_addr_d = 32'd0;
        state_d    = StIdle;
      end
      default: begin
        state_d  = StIdle;
        vec_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      epc_q      <= 32'd0;
      vec_addr_q <= 32'd0;
      vec_rd_q   <= 1'b0;
      code_q     <= 2'd0;
      byte_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      vec_addr_q <= vec_addr_d;
      vec_rd_q   <= vec_rd_d;
      code_q     <= code_d;
      byte_q     <= byte_d;
    end
  end

  assign pc_out   = pc_q;
  assign epc_out  = epc_q;
  assign vec_addr = vec_addr_q;
  assign vec_rd   = vec_rd_q;
  assign exc_busy = (state_q != StIdle);

endmodule

// File: tb/tb_pc_update_unit.sv
// Directed self-checking bench for pc_update_unit: reset, conditional writes,
// exception sequence, priority/lockout, EPC wrap and mid-sequence abort.
module tb_pc_update_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic        alu_gt;
  logic        exc_req;
  logic [1:0]  exc_code;
  logic [7:0]  mem_byte;
  logic [31:0] pc_out;
  logic [31:0] epc_out;
  logic [31:0] vec_addr;
  logic        vec_rd;
  logic        exc_busy;

  int checks = 0;
  int errors = 0;

  pc_update_unit dut (
    .clk          (clk),
    .reset        (reset),
    .pc_in        (pc_in),
    .pc_write     (pc_write),
    .pc_write_cond(pc_write_cond),
    .branch_op    (branch_op),
    .alu_zero     (alu_zero),
    .alu_gt       (alu_gt),
    .exc_req      (exc_req),
    .exc_code     (exc_code),
    .mem_byte     (mem_byte),
    .pc_out       (pc_out),
    .epc_out      (epc_out),
    .vec_addr     (vec_addr),
    .vec_rd       (vec_rd),
    .exc_busy     (exc_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    exc_req       = 1'b0;
    exc_code      = 2'd0;
    mem_byte      = 8'd0;
  endtask

  task automatic set_pc(input logic [31:0] v);
    pc_write = 1'b1;
    pc_in    = v;
    step();
    pc_write = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    pc_write = 1'b1;
    pc_in    = 32'h40;
    step();
    step();
    checks++; if (pc_out !== 32'h0) begin errors++;
      $display("FAIL reset_pc got %h exp %h", pc_out, 32'h0); end
    checks++; if (epc_out !== 32'h0) begin errors++;
      $display("FAIL reset_epc got %h exp %h", epc_out, 32'h0); end
    checks++; if (exc_busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b exp 0", exc_busy); end
    checks++; if (vec_rd !== 1'b0 || vec_addr !== 32'h0) begin errors++;
      $display("FAIL reset_vec got rd=%b addr=%h exp rd=0 addr=0", vec_rd, vec_addr); end
    reset = 1'b0;
    step();
    checks++; if (pc_out !== 32'h40) begin errors++;
      $display("FAIL first_write got %h exp %h", pc_out, 32'h40); end
    pc_write = 1'b0;
  endtask

  task automatic test_cond_write();
    // Flag combos (zero,gt): index 0=(1,0), 1=(0,1), 2=(0,0); bit i set => write expected.
    logic [2:0] mask [4];
    logic [1:0] zg [3];
    logic [31:0] exp_pc;
    mask[0] = 3'b001;  // BEQ
    mask[1] = 3'b110;  // BNE
    mask[2] = 3'b101;  // BLE
    mask[3] = 3'b010;  // BGT
    zg[0] = 2'b10;
    zg[1] = 2'b01;
    zg[2] = 2'b00;
    for (int op = 0; op < 4; op++) begin
      for (int c = 0; c < 3; c++) begin
        set_pc(32'h0);
        branch_op     = op[1:0];
        alu_zero      = zg[c][1];
        alu_gt        = zg[c][0];
        pc_in         = 32'h100;
        pc_write_cond = 1'b1;
        step();
        pc_write_cond = 1'b0;
        exp_pc = mask[op][c] ? 32'h100 : 32'h0;
        checks++; if (pc_out !== exp_pc) begin errors++;
          $display("FAIL cond_op%0d_combo%0d got %h exp %h", op, c, pc_out, exp_pc); end
      end
    end
    // Condition true but no request: PC must hold.
    set_pc(32'h0);
    branch_op = 2'd0; alu_zero = 1'b1; alu_gt = 1'b0; pc_in = 32'h100;
    step();
    checks++; if (pc_out !== 32'h0) begin errors++;
      $display("FAIL cond_no_req got %h exp %h", pc_out, 32'h0); end
  endtask

  task automatic test_exception();
    int busy_cnt;
    busy_cnt = 0;
    set_pc(32'h24);
    exc_req  = 1'b1;
    exc_code = 2'd1;
    step();  // E0
    exc_req = 1'b0;
    if (exc_busy === 1'b1) busy_cnt++;
    checks++; if (pc_out !== 32'h24) begin errors++;
      $display("FAIL exc_pc_e0 got %h exp %h", pc_out, 32'h24); end
    step();  // E1
    if (exc_busy === 1'b1) busy_cnt++;
    checks++; if (epc_out !== 32'h20) begin errors++;
      $display("FAIL exc_epc got %h exp %h", epc_out, 32'h20); end
    checks++; if (vec_rd !== 1'b1 || vec_addr !== 32'd254) begin errors++;
      $display("FAIL exc_vec got rd=%b addr=%0d exp rd=1 addr=254", vec_rd, vec_addr); end
    step();  // E2
    if (exc_busy === 1'b1) busy_cnt++;
    checks++; if (vec_rd !== 1'b0 || vec_addr !== 32'd254) begin errors++;
      $display("FAIL exc_wait got rd=%b addr=%0d exp rd=0 addr=254", vec_rd, vec_addr); end
    mem_byte = 8'h80;
    step();  // E3
    mem_byte = 8'h00;
    if (exc_busy === 1'b1) busy_cnt++;
    checks++; if (pc_out !== 32'h24) begin errors++;
      $display("FAIL exc_pc_e3 got %h exp %h", pc_out, 32'h24); end
    step();  // E4
    if (exc_busy === 1'b1) busy_cnt++;
    checks++; if (pc_out !== 32'h80) begin errors++;
      $display("FAIL exc_pc_load got %h exp %h", pc_out, 32'h80); end
    checks++; if (busy_cnt !== 4) begin errors++;
      $display("FAIL exc_busy_cycles got %0d exp 4", busy_cnt); end
    checks++; if (vec_addr !== 32'h0) begin errors++;
      $display("FAIL exc_vec_clear got %h exp 0", vec_addr); end
  endtask

  task automatic test_priority();
    set_pc(32'h24);
    exc_req  = 1'b1;
    exc_code = 2'd3;
    pc_write = 1'b1;
    pc_in    = 32'h500;
    step();  // E0
    checks++; if (pc_out !== 32'h24 || exc_busy !== 1'b1) begin errors++;
      $display("FAIL prio_e0 got pc=%h busy=%b exp pc=24 busy=1", pc_out, exc_busy); end
    pc_write_cond = 1'b1; branch_op = 2'd0; alu_zero = 1'b1;
    step();  // E1
    checks++; if (vec_addr !== 32'd253 || vec_rd !== 1'b1) begin errors++;
      $display("FAIL prio_code3 got addr=%0d rd=%b exp addr=253 rd=1", vec_addr, vec_rd); end
    exc_req = 1'b0;
    step();  // E2
    exc_req  = 1'b1;
    mem_byte = 8'h33;
    step();  // E3
    mem_byte = 8'h00;
    checks++; if (pc_out !== 32'h24) begin errors++;
      $display("FAIL prio_lockout got %h exp %h", pc_out, 32'h24); end
    step();  // E4
    idle_inputs();
    checks++; if (pc_out !== 32'h33 || exc_busy !== 1'b0) begin errors++;
      $display("FAIL prio_load got pc=%h busy=%b exp pc=33 busy=0", pc_out, exc_busy); end
    step();
    checks++; if (exc_busy !== 1'b0 || pc_out !== 32'h33) begin errors++;
      $display("FAIL prio_no_queue got busy=%b pc=%h exp busy=0 pc=33", exc_busy, pc_out); end
  endtask

  task automatic test_wrap_abort();
    set_pc(32'h0);
    exc_req  = 1'b1;
    exc_code = 2'd0;
    step();  // E0
    exc_req = 1'b0;
    step();  // E1
    checks++; if (epc_out !== 32'hFFFFFFFC) begin errors++;
      $display("FAIL wrap_epc got %h exp %h", epc_out, 32'hFFFFFFFC); end
    checks++; if (vec_addr !== 32'd253) begin errors++;
      $display("FAIL wrap_vec got %0d exp 253", vec_addr); end
    step();  // E2: now in WAIT
    reset    = 1'b1;
    mem_byte = 8'hAA;
    step();
    reset    = 1'b0;
    mem_byte = 8'h00;
    checks++; if (exc_busy !== 1'b0 || vec_rd !== 1'b0) begin errors++;
      $display("FAIL abort_ctrl got busy=%b rd=%b exp busy=0 rd=0", exc_busy, vec_rd); end
    checks++; if (pc_out !== 32'h0 || epc_out !== 32'h0 || vec_addr !== 32'h0) begin errors++;
      $display("FAIL abort_regs got pc=%h epc=%h addr=%h exp all 0", pc_out, epc_out, vec_addr); end
    step();
    checks++; if (exc_busy !== 1'b0 || pc_out !== 32'h0) begin errors++;
      $display("FAIL abort_idle got busy=%b pc=%h exp busy=0 pc=0", exc_busy, pc_out); end
  endtask

  initial begin
    reset     = 1'b1;
    pc_in     = 32'h0;
    branch_op = 2'd0;
    alu_zero  = 1'b0;
    alu_gt    = 1'b0;
    idle_inputs();
    #1;
    test_reset();
    test_cond_write();
    test_exception();
    test_priority();
    test_wrap_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
